// File: rtl/image_job_scheduler_if.sv
// Bundles the requester, image-processor and completion-record signals of the job scheduler.
// The scheduler connects through the master modport; the surrounding system uses slave.
interface image_job_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [2*NUM_REQ-1:0] req_op;
    logic [8*NUM_REQ-1:0] req_thresh;
    logic [8*NUM_REQ-1:0] req_bright;

    logic                 proc_start;
    logic [1:0]           proc_op;
    logic [7:0]           proc_thresh;
    logic [7:0]           proc_bright;
    logic                 proc_pixel_strobe;
    logic                 proc_done;

    logic                 cmp_valid;
    logic                 cmp_ready;
    logic [ID_W-1:0]      cmp_id;
    logic [31:0]          cmp_count;
    logic                 cmp_timeout;

    logic                 busy;

    modport master (
        input  req_valid, req_op, req_thresh, req_bright,
        input  proc_pixel_strobe, proc_done, cmp_ready,
        output req_ready, proc_start, proc_op, proc_thresh, proc_bright,
        output cmp_valid, cmp_id, cmp_count, cmp_timeout, busy
    );

    modport slave (
        output req_valid, req_op, req_thresh, req_bright,
        output proc_pixel_strobe, proc_done, cmp_ready,
        input  req_ready, proc_start, proc_op, proc_thresh, proc_bright,
        input  cmp_valid, cmp_id, cmp_count, cmp_timeout, busy
    );
endinterface

// File: rtl/image_job_scheduler.sv
// Round-robin job scheduler: grants one requester at a time, launches the image processor,
// counts processed pixels under a watchdog and hands back a completion record.
module image_job_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = 2,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                  clk,
    input  logic                  rst,
    image_job_scheduler_if.master bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, RUN, COMPLETE} state_e;

    state_e           state_q, state_d;
    logic [ID_W-1:0]  lastGrant_q;
    logic [ID_W-1:0]  ownerId_q;
    logic [1:0]       op_q;
    logic [7:0]       thresh_q;
    logic [7:0]       bright_q;
    logic [31:0]      pixCnt_q;
    logic [31:0]      wdog_q;
    logic             timeout_q;

    logic               winnerFound;
    logic [ID_W-1:0]    winnerId;
    logic [ID_W-1:0]    candId;
    logic [NUM_REQ-1:0] grantOneHot;
    logic [1:0]         selOp;
    logic [7:0]         selThresh;
    logic [7:0]         selBright;
    logic               accept;
    logic               wdogExpired;

    // Scan circularly from the requester after the last grant; the first valid one wins.
    always_comb begin
        winnerFound = 1'b0;
        winnerId    = '0;
        candId      = '0;
        grantOneHot = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            candId = ID_W'((int'(lastGrant_q) + k) % NUM_REQ);
            if (!winnerFound && bus.req_valid[candId]) begin
                winnerFound = 1'b1;
                winnerId    = candId;
            end
        end
        grantOneHot[winnerId] = winnerFound;
    end

    always_comb begin
        selOp     = '0;
        selThresh = '0;
        selBright = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winnerId == ID_W'(i)) begin
                selOp     = bus.req_op[2*i +: 2];
                selThresh = bus.req_thresh[8*i +: 8];
                selBright = bus.req_bright[8*i +: 8];
            end
        end
    end

    assign accept      = (state_q == IDLE) && winnerFound;
    assign wdogExpired = (wdog_q == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // proc_done wins over a simultaneous watchdog expiry.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (accept) state_d = ISSUE;
            ISSUE:    state_d = RUN;
            RUN:      if (bus.proc_done || wdogExpired) state_d = COMPLETE;
            COMPLETE: if (bus.cmp_ready) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = (state_q == IDLE) ? grantOneHot : '0;
        bus.proc_start = (state_q == ISSUE);
        bus.cmp_valid  = (state_q == COMPLETE);
        bus.busy       = (state_q != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lastGrant_q <= ID_W'(NUM_REQ - 1);
            ownerId_q   <= '0;
            op_q        <= '0;
            thresh_q    <= '0;
            bright_q    <= '0;
            pixCnt_q    <= '0;
            wdog_q      <= '0;
            timeout_q   <= 1'b0;
        end else begin
            if (accept) begin
                lastGrant_q <= winnerId;
                ownerId_q   <= winnerId;
                op_q        <= selOp;
                thresh_q    <= selThresh;
                bright_q    <= selBright;
            end
            case (state_q)
                ISSUE: begin
                    pixCnt_q  <= '0;
                    wdog_q    <= '0;
                    timeout_q <= 1'b0;
                end
                RUN: begin
                    if (bus.proc_pixel_strobe && (pixCnt_q != '1))
                        pixCnt_q <= pixCnt_q + 32'd1;
                    wdog_q <= wdog_q + 32'd1;
                    if (!bus.proc_done && wdogExpired)
                        timeout_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.proc_op     = op_q;
    assign bus.proc_thresh = thresh_q;
    assign bus.proc_bright = bright_q;
    assign bus.cmp_id      = ownerId_q;
    assign bus.cmp_count   = pixCnt_q;
    assign bus.cmp_timeout = timeout_q;

endmodule

// File: doc/image_job_scheduler.md
IMAGE_JOB_SCHEDULER -- requirements
Module: image_job_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requester ports.
REQ-002 SHALL have parameter ID_W, default 2: requester index width, equal to clog2(NUM_REQ).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1048576: RUN-state watchdog limit.
REQ-004 SHALL have port clk  in  1  clock, all logic on posedge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port req_valid  in  NUM_REQ  per-requester job request.
REQ-007 SHALL have port req_ready  out  NUM_REQ  one-hot job accept.
REQ-008 SHALL have port req_op  in  2*NUM_REQ  operation code, requester i in bits [2i+1:2i].
REQ-009 SHALL have port req_thresh  in  8*NUM_REQ  threshold, requester i in bits [8i+7:8i].
REQ-010 SHALL have port req_bright  in  8*NUM_REQ  brightness, requester i in bits [8i+7:8i].
REQ-011 SHALL have port proc_start  out  1  one-cycle start pulse to image processor.
REQ-012 SHALL have port proc_op / proc_thresh / proc_bright  out  2/8/8  latched job configuration.
REQ-013 SHALL have port proc_pixel_strobe  in  1  one-cycle pulse per processed pixel.
REQ-014 SHALL have port proc_done  in  1  processor completion pulse.
REQ-015 SHALL have port cmp_valid  out  1  completion record valid.
REQ-016 SHALL have port cmp_ready  in  1  completion record accepted.
REQ-017 SHALL have port cmp_id / cmp_count / cmp_timeout  out  ID_W/32/1  owner, pixel count, watchdog flag.
REQ-018 SHALL have port busy  out  1  high in every state except IDLE.

Function
REQ-019 SHALL implement states IDLE, ISSUE, RUN, COMPLETE.
REQ-020 SHALL, in IDLE, pick a winner round-robin starting at last_grant+1 modulo NUM_REQ among asserted req_valid bits.
REQ-021 SHALL drive req_ready combinationally as a one-hot of the winner only in IDLE; req_ready SHALL be all zero in every other state.
REQ-022 SHALL, on req_valid[g] & req_ready[g], latch op/thresh/bright and the id g, set last_grant=g, and go to ISSUE.
REQ-023 SHALL, in ISSUE, assert proc_start for exactly one cycle, clear pixel and watchdog counters, and go to RUN.
REQ-024 SHALL hold proc_op/thresh/bright stable from ISSUE until the next accepted request.
REQ-025 SHALL, in RUN, increment the pixel count on each proc_pixel_strobe, saturating at 2^32-1.
REQ-026 SHALL, in RUN, increment the watchdog counter every cycle.
REQ-027 SHALL, in RUN, go to COMPLETE with cmp_timeout=0 on proc_done.
REQ-028 SHALL otherwise go to COMPLETE with cmp_timeout=1 when the watchdog reaches TIMEOUT_CYCLES-1.
REQ-029 SHALL give proc_done priority when proc_done and the timeout condition occur in the same cycle; cmp_timeout=0.
REQ-030 SHALL include a strobe coinciding with proc_done in cmp_count.
REQ-031 SHALL, in COMPLETE, hold cmp_valid=1 and cmp_id/count/timeout stable until cmp_ready, then go to IDLE the following cycle.
REQ-032 SHALL ignore proc_done and proc_pixel_strobe outside RUN.
REQ-033 SHALL leave requests that are not granted pending; requesters hold req_valid and config until accepted.
REQ-034 SHALL impose a minimum latency from accept to proc_start of 1 cycle, and from proc_done to cmp_valid of 1 cycle.

Reset
REQ-035 SHALL, on rst, set state=IDLE and drive req_ready=0, proc_start=0, proc_op/thresh/bright=0, cmp_valid=0, cmp_id=0, cmp_count=0, cmp_timeout=0, busy=0.
REQ-036 SHALL, on rst, set last_grant=NUM_REQ-1 so that requester 0 wins first.
REQ-037 SHALL, on rst mid-job, abandon the job, emit no completion record, and issue no further proc_start until a new accept.

Verification
REQ-038 SHALL cover: req_valid=4'b0001, op=3, thresh=0x40 -> req_ready[0] pulse; proc_start 1 cycle later with proc_op=3; 5 strobes then done -> cmp_valid, cmp_id=0, cmp_count=5, cmp_timeout=0.
REQ-039 SHALL cover: all four req_valid held -> grants in order 0,1,2,3,0, with exactly one proc_start per grant.
REQ-040 SHALL cover: TIMEOUT_CYCLES=16 and no proc_done -> cmp_timeout=1 exactly 16 RUN cycles after entry.
REQ-041 SHALL cover: proc_done and a final strobe in the same cycle as timeout -> cmp_timeout=0 and the strobe counted.
REQ-042 SHALL cover: cmp_ready held low 10 cycles -> record stable, req_ready stays 0, and no new grant until the handshake.
REQ-043 SHALL cover: rst asserted in RUN -> all outputs at reset values next cycle, no cmp_valid, and the next grant goes to requester 0.
